// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the player move sequencer: grid constants, maze cell codes,
// FSM state encoding and the direction request encoding.
package move_sequencer_pkg;

  localparam int COORD_W  = 5;
  localparam int GRID_MAX = 23;

  typedef enum logic [2:0] {
    CELL_OCCUPIED   = 3'd0,
    CELL_AVAILABLE  = 3'd1,
    CELL_START      = 3'd2,
    CELL_END        = 3'd3,
    CELL_PLUS_FIVE  = 3'd5,
    CELL_MINUS_FIVE = 3'd6
  } cell_e;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CAPTURE    = 4'd1,
    ST_READ       = 4'd2,
    ST_WAIT_MEM   = 4'd3,
    ST_CHECK      = 4'd4,
    ST_WAIT_LEGAL = 4'd5,
    ST_COMMIT     = 4'd6,
    ST_DRAW       = 4'd7,
    ST_HALT       = 4'd8
  } state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Resolve simultaneous requests as Up > Down > Left > Right; at most one flag survives.
  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    dir_t d;
    d = '0;
    if (up) begin
      d.up = 1'b1;
    end else if (down) begin
      d.down = 1'b1;
    end else if (left) begin
      d.left = 1'b1;
    end else if (right) begin
      d.right = 1'b1;
    end else begin
      d = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/move_sequencer_candidate_calc.sv
// Combinational candidate-cell former. A step off the grid edge saturates to the current
// cell; the held direction flag is what lets the checker reject such a move.
module move_candidate_calc
  import move_sequencer_pkg::*;
#(
  parameter int MAX_COORD = GRID_MAX
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  dir_t               dir_i,
  output logic [COORD_W-1:0] cand_x_o,
  output logic [COORD_W-1:0] cand_y_o
);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX_COORD);
  localparam logic [COORD_W-1:0] ZERO  = COORD_W'(0);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  // Step one cell in the requested direction unless already on that edge.
  always_comb begin
    cand_x_o = x_i;
    cand_y_o = y_i;
    if (dir_i.left && (x_i != ZERO)) begin
      cand_x_o = x_i - ONE;
    end else if (dir_i.right && (x_i != MAX_C)) begin
      cand_x_o = x_i + ONE;
    end else begin
      cand_x_o = x_i;
    end
    if (dir_i.up && (y_i != ZERO)) begin
      cand_y_o = y_i - ONE;
    end else if (dir_i.down && (y_i != MAX_C)) begin
      cand_y_o = y_i + ONE;
    end else begin
      cand_y_o = y_i;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Player move sequencer: captures one direction request, reads the candidate maze cell,
// hands it to the legality checker, then commits or discards the move and requests a redraw.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int MAX_COORD     = GRID_MAX,
  parameter int START_X       = 0,
  parameter int START_Y       = 1,
  parameter int MOVE_BUDGET   = 99,
  parameter int MOVE_W        = 7,
  parameter int MEM_LATENCY   = 1,
  parameter int LEGAL_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  moveLeft,
  input  logic                  moveRight,
  input  logic                  moveUp,
  input  logic                  moveDown,
  output logic [2*COORD_W-1:0]  memAddress,
  input  logic [2:0]            memData,
  output logic [2:0]            valueInMemory,
  output logic [COORD_W-1:0]    candX,
  output logic [COORD_W-1:0]    candY,
  output logic                  dirLeft,
  output logic                  dirRight,
  output logic                  dirUp,
  output logic                  dirDown,
  output logic                  doneChangePosition,
  input  logic                  doneCheckLegal,
  input  logic                  isLegal,
  input  logic                  gameWon,
  input  logic                  gameOver,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic [MOVE_W-1:0]     movesLeft,
  output logic                  noMoreMoves,
  output logic                  drawReq,
  input  logic                  drawDone,
  output logic                  busy
);

  localparam int                 TMR_W    = $clog2(LEGAL_TIMEOUT + 1);
  localparam logic [1:0]         LAT_LAST = 2'(MEM_LATENCY - 1);
  localparam logic [TMR_W-1:0]   TMO_LAST = TMR_W'(LEGAL_TIMEOUT - 1);
  localparam logic [MOVE_W-1:0]  BUDGET   = MOVE_W'(MOVE_BUDGET);
  localparam logic [COORD_W-1:0] X_RST    = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_RST    = COORD_W'(START_Y);

  state_e              state_q,   state_d;
  dir_t                dir_q,     dir_d;
  logic [COORD_W-1:0]  cand_x_q,  cand_x_d;
  logic [COORD_W-1:0]  cand_y_q,  cand_y_d;
  logic [2:0]          value_q,   value_d;
  logic [COORD_W-1:0]  x_q,       x_d;
  logic [COORD_W-1:0]  y_q,       y_d;
  logic [MOVE_W-1:0]   moves_q,   moves_d;
  logic [1:0]          mem_cnt_q, mem_cnt_d;
  logic [TMR_W-1:0]    tmr_q,     tmr_d;
  logic                legal_q,   legal_d;
  logic                done_q,    done_d;
  logic                draw_q,    draw_d;
  logic                busy_q,    busy_d;
  logic                no_more_q, no_more_d;
  logic [COORD_W-1:0]  calc_x,    calc_y;
  logic                req_any;

  move_candidate_calc #(
    .MAX_COORD (MAX_COORD)
  ) u_cand (
    .x_i      (x_q),
    .y_i      (y_q),
    .dir_i    (dir_q),
    .cand_x_o (calc_x),
    .cand_y_o (calc_y)
  );

  assign req_any = moveUp | moveDown | moveLeft | moveRight;

  // Next-state and datapath update; every output is decoded from the next state so it is registered.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    value_d   = value_q;
    x_d       = x_q;
    y_d       = y_q;
    moves_d   = moves_q;
    mem_cnt_d = mem_cnt_q;
    tmr_d     = tmr_q;
    legal_d   = legal_q;
    case (state_q)
      ST_IDLE: begin
        if (!no_more_q && req_any) begin
          dir_d   = pick_dir(moveUp, moveDown, moveLeft, moveRight);
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        cand_x_d = calc_x;
        cand_y_d = calc_y;
        state_d  = ST_READ;
      end
      ST_READ: begin
        mem_cnt_d = 2'd0;
        state_d   = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (mem_cnt_q == LAT_LAST) begin
          value_d = memData;
          state_d = ST_CHECK;
        end else begin
          mem_cnt_d = mem_cnt_q + 2'd1;
          state_d   = ST_WAIT_MEM;
        end
      end
      ST_CHECK: begin
        tmr_d   = '0;
        state_d = ST_WAIT_LEGAL;
      end
      ST_WAIT_LEGAL: begin
        if (doneCheckLegal) begin
          legal_d = isLegal;
          if (gameWon || gameOver) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_COMMIT;
          end
        end else if (tmr_q == TMO_LAST) begin
          legal_d = 1'b0;
          state_d = ST_COMMIT;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
          state_d = ST_WAIT_LEGAL;
        end
      end
      ST_COMMIT: begin
        // An illegal attempt still costs a move.
        moves_d = (moves_q == '0) ? moves_q : moves_q - MOVE_W'(1);
        if (legal_q) begin
          x_d     = cand_x_q;
          y_d     = cand_y_q;
          state_d = ST_DRAW;
        end else begin
          dir_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (drawDone) begin
          dir_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        dir_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    done_d    = (state_d == ST_CHECK);
    draw_d    = (state_d == ST_DRAW);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_HALT);
    no_more_d = (moves_d == '0);
  end

  // State and datapath registers with asynchronous return to the start-of-game values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      dir_q     <= '0;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      value_q   <= 3'd0;
      x_q       <= X_RST;
      y_q       <= Y_RST;
      moves_q   <= BUDGET;
      mem_cnt_q <= 2'd0;
      tmr_q     <= '0;
      legal_q   <= 1'b0;
      done_q    <= 1'b0;
      draw_q    <= 1'b0;
      busy_q    <= 1'b0;
      no_more_q <= (MOVE_BUDGET == 0);
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      value_q   <= value_d;
      x_q       <= x_d;
      y_q       <= y_d;
      moves_q   <= moves_d;
      mem_cnt_q <= mem_cnt_d;
      tmr_q     <= tmr_d;
      legal_q   <= legal_d;
      done_q    <= done_d;
      draw_q    <= draw_d;
      busy_q    <= busy_d;
      no_more_q <= no_more_d;
    end
  end

  assign memAddress         = {cand_y_q, cand_x_q};
  assign valueInMemory      = value_q;
  assign candX              = cand_x_q;
  assign candY              = cand_y_q;
  assign dirUp              = dir_q.up;
  assign dirDown            = dir_q.down;
  assign dirLeft            = dir_q.left;
  assign dirRight           = dir_q.right;
  assign doneChangePosition = done_q;
  assign x                  = x_q;
  assign y                  = y_q;
  assign movesLeft          = moves_q;
  assign noMoreMoves        = no_more_q;
  assign drawReq            = draw_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: each accepted request pushes the expected checker
// hand-off, which is popped and compared when doneChangePosition pulses.
module tb_move_sequencer;

  localparam int MEM_LAT = 1;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        moveLeft = 1'b0, moveRight = 1'b0, moveUp = 1'b0, moveDown = 1'b0;
  logic [9:0]  memAddress;
  logic [2:0]  memData;
  logic [2:0]  valueInMemory;
  logic [4:0]  candX, candY;
  logic        dirLeft, dirRight, dirUp, dirDown;
  logic        doneChangePosition;
  logic        doneCheckLegal = 1'b0, isLegal = 1'b0, gameWon = 1'b0, gameOver = 1'b0;
  logic [4:0]  x, y;
  logic [6:0]  movesLeft;
  logic        noMoreMoves, drawReq, busy;
  logic        drawDone = 1'b0;

  typedef struct {
    int         cyc;
    logic [4:0] cx;
    logic [4:0] cy;
    logic [3:0] dir;
    logic [2:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   snap;

  move_sequencer dut (
    .clock(clock), .resetn(resetn),
    .moveLeft(moveLeft), .moveRight(moveRight), .moveUp(moveUp), .moveDown(moveDown),
    .memAddress(memAddress), .memData(memData), .valueInMemory(valueInMemory),
    .candX(candX), .candY(candY),
    .dirLeft(dirLeft), .dirRight(dirRight), .dirUp(dirUp), .dirDown(dirDown),
    .doneChangePosition(doneChangePosition), .doneCheckLegal(doneCheckLegal),
    .isLegal(isLegal), .gameWon(gameWon), .gameOver(gameOver),
    .x(x), .y(y), .movesLeft(movesLeft), .noMoreMoves(noMoreMoves),
    .drawReq(drawReq), .drawDone(drawDone), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Maze contents as a function of the cell, so a stale or early read shows up.
  function automatic logic [2:0] cell_of(input logic [4:0] cx, input logic [4:0] cy);
    logic [5:0] s;
    s = {1'b0, cx} + {1'b0, cy};
    case (s[1:0])
      2'd0:    return 3'd0;
      2'd1:    return 3'd5;
      2'd2:    return 3'd1;
      default: return 3'd6;
    endcase
  endfunction

  // One-cycle-latency maze RAM.
  always @(posedge clock) memData <= cell_of(memAddress[4:0], memAddress[9:5]);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every hand-off pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (resetn && doneChangePosition) begin
      n_done++;
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("done_latency", cyc, e.cyc);
        check_val("candX", candX, e.cx);
        check_val("candY", candY, e.cy);
        check_val("memAddress", memAddress, {e.cy, e.cx});
        check_val("dir", {dirUp, dirDown, dirLeft, dirRight}, e.dir);
        check_val("valueInMemory", valueInMemory, e.val);
      end
    end
  end

  // req and edir are {up, down, left, right}.
  task automatic issue(input logic [3:0] req, input logic [4:0] cx, input logic [4:0] cy,
                       input logic [3:0] edir, input logic accepted);
    @(negedge clock);
    if (accepted) sb.push_back('{cyc + 3 + MEM_LAT, cx, cy, edir, cell_of(cx, cy)});
    {moveUp, moveDown, moveLeft, moveRight} = req;
    @(negedge clock);
    {moveUp, moveDown, moveLeft, moveRight} = 4'b0000;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!doneChangePosition && i < budget) begin
      @(negedge clock);
      i++;
    end
    if (!doneChangePosition) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic give_verdict(input logic legal, input logic won);
    doneCheckLegal = 1'b1;
    isLegal = legal;
    gameWon = won;
    @(negedge clock);
    doneCheckLegal = 1'b0;
    isLegal = 1'b0;
    gameWon = 1'b0;
  endtask

  task automatic finish_draw();
    repeat (2) @(negedge clock);
    check_val("drawReq_hold", drawReq, 1'b1);
    drawDone = 1'b1;
    @(negedge clock);
    drawDone = 1'b0;
    check_val("drawReq_drop", drawReq, 1'b0);
    check_val("busy_after_draw", busy, 1'b0);
    check_val("dir_clear", {dirUp, dirDown, dirLeft, dirRight}, 4'b0000);
  endtask

  task automatic reset_mid(input string tag);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check_val({tag, "_x"}, x, 5'd0);
    check_val({tag, "_y"}, y, 5'd1);
    check_val({tag, "_moves"}, movesLeft, 7'd99);
    check_val({tag, "_drawReq"}, drawReq, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_nomore"}, noMoreMoves, 1'b0);
    sb.delete();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_val("rst_x", x, 5'd0);
    check_val("rst_y", y, 5'd1);
    check_val("rst_moves", movesLeft, 7'd99);
    check_val("rst_nomore", noMoreMoves, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_drawReq", drawReq, 1'b0);
    check_val("rst_done", doneChangePosition, 1'b0);
    check_val("rst_addr", memAddress, 10'd0);
    check_val("rst_value", valueInMemory, 3'd0);
    check_val("rst_dir", {dirUp, dirDown, dirLeft, dirRight}, 4'b0000);
    resetn = 1'b1;

    // Legal move right from (0,1).
    issue(4'b0001, 5'd1, 5'd1, 4'b0001, 1'b1);
    wait_done(20);
    @(negedge clock);
    give_verdict(1'b1, 1'b0);
    @(negedge clock);
    check_val("t1_x", x, 5'd1);
    check_val("t1_y", y, 5'd1);
    check_val("t1_moves", movesLeft, 7'd98);
    check_val("t1_drawReq", drawReq, 1'b1);
    check_val("t1_busy", busy, 1'b1);
    finish_draw();

    // Legal move left back to the edge.
    issue(4'b0010, 5'd0, 5'd1, 4'b0010, 1'b1);
    wait_done(20);
    @(negedge clock);
    give_verdict(1'b1, 1'b0);
    @(negedge clock);
    check_val("back_x", x, 5'd0);
    finish_draw();

    // Left at x=0 saturates; rejected move costs a move and skips the redraw.
    issue(4'b0010, 5'd0, 5'd1, 4'b0010, 1'b1);
    wait_done(20);
    @(negedge clock);
    check_val("t2_dirLeft_held", dirLeft, 1'b1);
    check_val("t2_candX_held", candX, 5'd0);
    give_verdict(1'b0, 1'b0);
    @(negedge clock);
    check_val("t2_x", x, 5'd0);
    check_val("t2_moves", movesLeft, 7'd96);
    check_val("t2_drawReq", drawReq, 1'b0);
    check_val("t2_busy", busy, 1'b0);
    check_val("t2_dir_clear", dirLeft, 1'b0);

    // Up and Left together: Up wins; a request during WAIT_LEGAL is dropped.
    snap = n_done;
    issue(4'b1010, 5'd0, 5'd0, 4'b1000, 1'b1);
    wait_done(20);
    @(negedge clock);
    moveDown = 1'b1;
    @(negedge clock);
    moveDown = 1'b0;
    give_verdict(1'b1, 1'b0);
    @(negedge clock);
    check_val("t3_y", y, 5'd0);
    check_val("t3_x", x, 5'd0);
    finish_draw();
    repeat (8) @(negedge clock);
    check_val("t3_one_done", n_done, snap + 1);
    check_val("t3_moves", movesLeft, 7'd95);

    // No verdict: 15 cycles of WAIT_LEGAL, one COMMIT cycle, then IDLE.
    issue(4'b0100, 5'd0, 5'd1, 4'b0100, 1'b1);
    wait_done(20);
    repeat (16) @(negedge clock);
    check_val("t4_commit_busy", busy, 1'b1);
    @(negedge clock);
    check_val("t4_idle_busy", busy, 1'b0);
    check_val("t4_y", y, 5'd0);
    check_val("t4_moves", movesLeft, 7'd94);
    check_val("t4_drawReq", drawReq, 1'b0);

    // Spend the remaining budget on rejected moves.
    for (int i = 0; i < 94; i++) begin
      if (i == 93) begin
        check_val("t5_last_move", movesLeft, 7'd1);
        check_val("t5_nomore_before", noMoreMoves, 1'b0);
      end
      issue(4'b0010, 5'd0, 5'd0, 4'b0010, 1'b1);
      wait_done(20);
      @(negedge clock);
      give_verdict(1'b0, 1'b0);
      @(negedge clock);
    end
    check_val("t5_moves_zero", movesLeft, 7'd0);
    check_val("t5_nomore", noMoreMoves, 1'b1);
    snap = n_done;
    issue(4'b0001, 5'd0, 5'd0, 4'b0000, 1'b0);
    repeat (8) @(negedge clock);
    check_val("t5_ignored_busy", busy, 1'b0);
    check_val("t5_ignored_done", n_done, snap);
    check_val("t5_moves_sat", movesLeft, 7'd0);

    reset_mid("rst_drained");

    // Reset while the redraw is outstanding.
    issue(4'b0001, 5'd1, 5'd1, 4'b0001, 1'b1);
    wait_done(20);
    @(negedge clock);
    give_verdict(1'b1, 1'b0);
    @(negedge clock);
    finish_draw();
    issue(4'b0001, 5'd2, 5'd1, 4'b0001, 1'b1);
    wait_done(20);
    @(negedge clock);
    give_verdict(1'b1, 1'b0);
    @(negedge clock);
    check_val("t6_x_before", x, 5'd2);
    check_val("t6_drawReq_before", drawReq, 1'b1);
    reset_mid("rst_draw");

    // Reset while waiting on the maze RAM.
    issue(4'b0001, 5'd1, 5'd1, 4'b0001, 1'b1);
    wait_done(20);
    @(negedge clock);
    give_verdict(1'b1, 1'b0);
    @(negedge clock);
    finish_draw();
    issue(4'b0001, 5'd2, 5'd1, 4'b0001, 1'b1);
    @(negedge clock);
    check_val("t6_busy_before", busy, 1'b1);
    reset_mid("rst_waitmem");

    // Winning verdict halts; later requests produce nothing.
    issue(4'b0001, 5'd1, 5'd1, 4'b0001, 1'b1);
    wait_done(20);
    @(negedge clock);
    give_verdict(1'b1, 1'b1);
    check_val("halt_busy", busy, 1'b0);
    check_val("halt_drawReq", drawReq, 1'b0);
    snap = n_done;
    issue(4'b0001, 5'd0, 5'd0, 4'b0000, 1'b0);
    repeat (10) @(negedge clock);
    check_val("halt_busy_after_req", busy, 1'b0);
    check_val("halt_no_done", n_done, snap);
    check_val("halt_moves", movesLeft, 7'd99);
    check_val("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
